// File: rtl/alu_step_sequencer.sv
// Control-step sequencer for register-register ALU instructions: drives the
// T3..T6 bus strobes for narrow (Ra) and wide (HI/LO) results.
module alu_step_sequencer #(
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned SEL_W     = $clog2(NUM_REGS),
  parameter int unsigned ALU_SEL_W = 5,
  parameter int unsigned ALU_LAT   = 1,
  parameter int unsigned WIDE_LAT  = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic [ALU_SEL_W-1:0] op,
  input  logic                 wide,
  input  logic [SEL_W-1:0]     ra,
  input  logic [SEL_W-1:0]     rb,
  input  logic [SEL_W-1:0]     rc,
  output logic [NUM_REGS-1:0]  Rout,
  output logic [NUM_REGS-1:0]  Rin,
  output logic                 Yin,
  output logic                 Zin,
  output logic                 ZLOout,
  output logic                 ZHIout,
  output logic                 LOin,
  output logic                 HIin,
  output logic [ALU_SEL_W-1:0] alu_sel,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_T3, S_T4, S_T5, S_T6, S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] ALU_CNT  = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] WIDE_CNT = CNT_W'(WIDE_LAT - 1);

  state_e               state_q, state_d;
  logic [ALU_SEL_W-1:0] op_q, op_d;
  logic                 wide_q, wide_d;
  logic [SEL_W-1:0]     ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 idx_ok;

  // Widened compare so a power-of-two register count is not a constant test.
  assign idx_ok = (32'(ra) < NUM_REGS) && (32'(rb) < NUM_REGS) && (32'(rc) < NUM_REGS);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      wide_q  <= 1'b0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wide_q  <= wide_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wide_d  = wide_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    cnt_d   = cnt_q;
    Rout    = '0;
    Rin     = '0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    ZLOout  = 1'b0;
    ZHIout  = 1'b0;
    LOin    = 1'b0;
    HIin    = 1'b0;
    alu_sel = '0;
    busy    = 1'b1;
    done    = 1'b0;
    err     = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (idx_ok) begin
            op_d    = op;
            wide_d  = wide;
            ra_d    = ra;
            rb_d    = rb;
            rc_d    = rc;
            state_d = S_T3;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_ERR: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
      S_T3: begin
        Rout    = NUM_REGS'(1) << rb_q;
        Yin     = 1'b1;
        cnt_d   = wide_q ? WIDE_CNT : ALU_CNT;
        state_d = S_T4;
      end
      S_T4: begin
        Rout    = NUM_REGS'(1) << rc_q;
        Zin     = 1'b1;
        alu_sel = op_q;
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = S_T5;
      end
      S_T5: begin
        ZLOout = 1'b1;
        if (wide_q) begin
          LOin    = 1'b1;
          state_d = S_T6;
        end else begin
          Rin     = NUM_REGS'(1) << ra_q;
          state_d = S_DONE;
        end
      end
      S_T6: begin
        ZHIout  = 1'b1;
        HIin    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Scoreboard bench for alu_step_sequencer: expected per-cycle strobe sets are
// queued at issue time and popped by a negedge monitor; a tiny datapath checks results.
module tb_alu_step_sequencer;

  typedef struct packed {
    logic [15:0] rout;
    logic [15:0] rin;
    logic yin, zin, zlo, zhi, loin, hiin;
    logic [4:0] alu_sel;
    logic busy, done, err;
  } obs_t;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_MUL = 5'b01110;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  logic       start_i [2];
  logic [4:0] op_i    [2];
  logic       wide_i  [2];
  logic [3:0] ra_i    [2];
  logic [3:0] rb_i    [2];
  logic [3:0] rc_i    [2];

  logic [15:0] rout0, rin0;
  logic [11:0] rout1, rin1;
  logic yin0, zin0, zlo0, zhi0, loin0, hiin0, busy0, done0, err0;
  logic yin1, zin1, zlo1, zhi1, loin1, hiin1, busy1, done1, err1;
  logic [4:0] sel0, sel1;
  obs_t obs0, obs1;

  assign obs0 = {rout0, rin0, yin0, zin0, zlo0, zhi0, loin0, hiin0, sel0, busy0, done0, err0};
  assign obs1 = {4'b0, rout1, 4'b0, rin1, yin1, zin1, zlo1, zhi1, loin1, hiin1, sel1, busy1, done1, err1};

  alu_step_sequencer dut0 (
    .clk(clk), .clr(clr), .start(start_i[0]), .op(op_i[0]), .wide(wide_i[0]),
    .ra(ra_i[0]), .rb(rb_i[0]), .rc(rc_i[0]), .Rout(rout0), .Rin(rin0),
    .Yin(yin0), .Zin(zin0), .ZLOout(zlo0), .ZHIout(zhi0), .LOin(loin0), .HIin(hiin0),
    .alu_sel(sel0), .busy(busy0), .done(done0), .err(err0)
  );

  alu_step_sequencer #(.NUM_REGS(12), .ALU_LAT(3)) dut1 (
    .clk(clk), .clr(clr), .start(start_i[1]), .op(op_i[1]), .wide(wide_i[1]),
    .ra(ra_i[1]), .rb(rb_i[1]), .rc(rc_i[1]), .Rout(rout1), .Rin(rin1),
    .Yin(yin1), .Zin(zin1), .ZLOout(zlo1), .ZHIout(zhi1), .LOin(loin1), .HIin(hiin1),
    .alu_sel(sel1), .busy(busy1), .done(done1), .err(err1)
  );

  obs_t q0[$];
  obs_t q1[$];

  // Bench datapath driven by dut0's strobes.
  logic [31:0] regs [16];
  logic [31:0] y_r, lo_r, hi_r;
  logic [63:0] z_r;

  int idle_run0  = 0;
  int last_gap0  = -1;
  logic prev_busy0 = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpush(input int k, input obs_t e);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  function automatic logic [63:0] alu(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      OP_SUB:  return 64'(a - b);
      OP_MUL:  return 64'(a) * 64'(b);
      default: return 64'(a + b);
    endcase
  endfunction

  task automatic mon(input int k, input obs_t o);
    obs_t e;
    int nd, nr;
    logic [31:0] bus;
    nd = ((o.rout != 16'h0) ? 1 : 0) + int'(o.zlo) + int'(o.zhi);
    nr = ((o.rin != 16'h0) ? 1 : 0) + int'(o.loin) + int'(o.hiin);
    chk("rout_onehot", 64'($countones(o.rout) <= 1), 64'(1));
    chk("rin_onehot", 64'($countones(o.rin) <= 1), 64'(1));
    chk("single_driver", 64'(nd <= 1), 64'(1));
    chk("single_sink", 64'(nr <= 1), 64'(1));
    if (o.busy) begin
      if (qsize(k) == 0) begin
        chk($sformatf("unexpected_busy%0d", k), 64'(o), 64'(0));
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("cycle%0d", k), 64'(o), 64'(e));
      end
    end else begin
      chk($sformatf("idle_quiet%0d", k), 64'(o), 64'(0));
    end
    if (k == 0) begin
      bus = 32'h0;
      for (int r = 0; r < 16; r++) if (o.rout[r]) bus = regs[r];
      if (o.zlo) bus = z_r[31:0];
      if (o.zhi) bus = z_r[63:32];
      if (o.zin) z_r = alu(o.alu_sel, y_r, bus);
      if (o.yin) y_r = bus;
      for (int r = 0; r < 16; r++) if (o.rin[r]) regs[r] = bus;
      if (o.loin) lo_r = bus;
      if (o.hiin) hi_r = bus;
      if (o.busy) begin
        if (!prev_busy0) last_gap0 = idle_run0;
        idle_run0 = 0;
      end else begin
        idle_run0++;
      end
      prev_busy0 = o.busy;
    end
  endtask

  always @(negedge clk) begin
    if (!clr) begin
      mon(0, obs0);
      mon(1, obs1);
    end
  end

  task automatic push_seq(input int k, input logic [4:0] o, input logic w,
                          input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input int lat);
    obs_t e;
    e = '0; e.rout = 16'(1) << b; e.yin = 1'b1; e.busy = 1'b1; qpush(k, e);
    for (int i = 0; i < lat; i++) begin
      e = '0; e.rout = 16'(1) << c; e.zin = 1'b1; e.alu_sel = o; e.busy = 1'b1; qpush(k, e);
    end
    e = '0; e.zlo = 1'b1; e.busy = 1'b1;
    if (w) e.loin = 1'b1;
    else   e.rin = 16'(1) << a;
    qpush(k, e);
    if (w) begin
      e = '0; e.zhi = 1'b1; e.hiin = 1'b1; e.busy = 1'b1; qpush(k, e);
    end
    e = '0; e.done = 1'b1; e.busy = 1'b1; qpush(k, e);
  endtask

  task automatic drive(input int k, input logic [4:0] o, input logic w,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    op_i[k] = o; wide_i[k] = w; ra_i[k] = a; rb_i[k] = b; rc_i[k] = c;
    start_i[k] = 1'b1;
  endtask

  task automatic issue(input int k, input logic [4:0] o, input logic w,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input int lat, output int acc);
    push_seq(k, o, w, a, b, c, lat);
    drive(k, o, w, a, b, c);
    @(posedge clk); #1;
    acc = cyc;
    start_i[k] = 1'b0;
  endtask

  // Latency counts edges from the accepting edge to the edge that samples done.
  task automatic wait_done(input int k, input int acc, input int exp_lat, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if ((k == 0) ? done0 : done1) begin
        seen = 1'b1;
        chk(name, 64'(cyc + 1 - acc), 64'(exp_lat));
      end
    end
    if (!seen) chk({name, "_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic drain(input int k, input string name);
    @(posedge clk); #1;
    chk(name, 64'(qsize(k)), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct { logic [3:0] a, b, c; } idx_t;
  idx_t bad [3];

  initial begin
    int acc;
    obs_t e;
    for (int k = 0; k < 2; k++) begin
      start_i[k] = 1'b0; op_i[k] = '0; wide_i[k] = 1'b0;
      ra_i[k] = '0; rb_i[k] = '0; rc_i[k] = '0;
    end
    for (int r = 0; r < 16; r++) regs[r] = 32'h0;
    y_r = '0; z_r = '0; lo_r = 32'hdead; hi_r = 32'hbeef;

    #2;
    chk("reset_obs0", 64'(obs0), 64'(0));
    chk("reset_obs1", 64'(obs1), 64'(0));
    #10 clr = 1'b0;
    @(posedge clk); #1;

    // 1: narrow sub R4-R5 -> R0
    regs[4] = 32'd10; regs[5] = 32'd2;
    issue(0, OP_SUB, 1'b0, 4'd0, 4'd4, 4'd5, 1, acc);
    wait_done(0, acc, 4, "lat_sub");
    drain(0, "queue_sub");
    chk("R0", 64'(regs[0]), 64'd8);

    // 2: wide mul -> HI/LO
    regs[4] = 32'h10000; regs[5] = 32'h10000;
    issue(0, OP_MUL, 1'b1, 4'd0, 4'd4, 4'd5, 4, acc);
    wait_done(0, acc, 8, "lat_mul");
    drain(0, "queue_mul");
    chk("LO", 64'(lo_r), 64'h0);
    chk("HI", 64'(hi_r), 64'h1);

    // 3a: start pulse during T4 is ignored
    issue(0, OP_ADD, 1'b1, 4'd2, 4'd4, 4'd5, 4, acc);
    @(posedge clk); #1;
    drive(0, OP_SUB, 1'b0, 4'd1, 4'd6, 4'd7);
    @(posedge clk); #1;
    start_i[0] = 1'b0;
    wait_done(0, acc, 8, "lat_busy_ignore");
    repeat (3) @(posedge clk);
    #1 chk("queue_busy_ignore", 64'(qsize(0)), 64'(0));

    // 3b: start held through done, operands changed after accept
    push_seq(0, OP_SUB, 1'b0, 4'd1, 4'd4, 4'd5, 1);
    push_seq(0, OP_ADD, 1'b0, 4'd2, 4'd5, 4'd4, 1);
    drive(0, OP_SUB, 1'b0, 4'd1, 4'd4, 4'd5);
    @(posedge clk); #1;
    acc = cyc;
    drive(0, OP_ADD, 1'b0, 4'd2, 4'd5, 4'd4);
    wait_done(0, acc, 4, "lat_b2b_first");
    @(posedge clk);
    @(posedge clk); #1;
    acc = cyc;
    start_i[0] = 1'b0;
    wait_done(0, acc, 4, "lat_b2b_second");
    drain(0, "queue_b2b");
    chk("idle_gap", 64'(last_gap0), 64'(1));

    // 4: async clear during T4
    issue(0, OP_MUL, 1'b1, 4'd0, 4'd4, 4'd5, 4, acc);
    @(posedge clk); #1;
    @(negedge clk); #2;
    clr = 1'b1;
    #1 chk("clr_immediate", 64'(obs0), 64'(0));
    q0.delete();
    @(posedge clk); #1;
    chk("clr_held", 64'(obs0), 64'(0));
    #3 clr = 1'b0;
    @(posedge clk); #1;
    regs[4] = 32'd9; regs[5] = 32'd4;
    issue(0, OP_SUB, 1'b0, 4'd6, 4'd4, 4'd5, 1, acc);
    wait_done(0, acc, 4, "lat_after_clr");
    drain(0, "queue_after_clr");
    chk("R6", 64'(regs[6]), 64'd5);

    // 5: illegal indices on the 12-register instance
    bad[0] = '{a: 4'd1,  b: 4'd2,  c: 4'd13};
    bad[1] = '{a: 4'd12, b: 4'd2,  c: 4'd3};
    bad[2] = '{a: 4'd0,  b: 4'd15, c: 4'd3};
    for (int i = 0; i < 3; i++) begin
      e = '0; e.busy = 1'b1; e.err = 1'b1;
      qpush(1, e);
      drive(1, OP_ADD, 1'b0, bad[i].a, bad[i].b, bad[i].c);
      @(posedge clk); #1;
      start_i[1] = 1'b0;
      drain(1, $sformatf("err_queue%0d", i));
      chk($sformatf("err_idle%0d", i), 64'(busy1), 64'(0));
    end
    issue(1, OP_ADD, 1'b0, 4'd0, 4'd11, 4'd2, 3, acc);
    wait_done(1, acc, 6, "lat_legal_after_err");
    drain(1, "queue_legal_after_err");

    // 6: aliasing R3-R3->R3 at ALU_LAT 1 and 3
    regs[3] = 32'd7;
    issue(0, OP_SUB, 1'b0, 4'd3, 4'd3, 4'd3, 1, acc);
    wait_done(0, acc, 4, "lat_alias1");
    drain(0, "queue_alias1");
    chk("R3", 64'(regs[3]), 64'd0);
    issue(1, OP_SUB, 1'b0, 4'd3, 4'd3, 4'd3, 3, acc);
    wait_done(1, acc, 6, "lat_alias3");
    drain(1, "queue_alias3");

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_step_sequencer.md
Name: alu_step_sequencer

Overview:
Parametrised control-step sequencer for register-register ALU instructions on the CPU datapath bus. On a start request it drives the one-hot register-out/in strobes, Yin, Zin, ALU select, ZLOout/ZHIout and HIin/LOin in the fixed T3..T6 step order. It replaces hand-sequenced control steps in benches and in the future control unit. It supports narrow ops that write Ra, wide ops that write HI/LO, and programmable ALU latency for multicycle ops such as div.

Parameters:
NUM_REGS, 16, number of general registers; width of the one-hot Rin/Rout buses.
SEL_W, $clog2(NUM_REGS), register index width (derived).
ALU_SEL_W, 5, ALU select width.
ALU_LAT, 1, cycles T4 is held for narrow ops (>=1).
WIDE_LAT, 4, cycles T4 is held for wide ops (>=1).
CNT_W, 8, latency counter width; ALU_LAT and WIDE_LAT must be < 2^CNT_W.

Ports:
clk  in  1  clock, rising edge.
clr  in  1  asynchronous active-high reset.
start  in  1  request; sampled only in IDLE.
op  in  ALU_SEL_W  ALU select for this instruction.
wide  in  1  1 = 64-bit result: ZLO->LO, ZHI->HI; Ra is ignored.
ra  in  SEL_W  destination register index.
rb  in  SEL_W  first operand, routed via Y.
rc  in  SEL_W  second operand, driven on bus during T4.
Rout  out  NUM_REGS  one-hot register-out strobes.
Rin  out  NUM_REGS  one-hot register-in strobes.
Yin, Zin, ZLOout, ZHIout, LOin, HIin  out  1 each  datapath strobes.
alu_sel  out  ALU_SEL_W  ALU select.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle completion pulse.
err  out  1  one-cycle pulse: start rejected for an illegal index.

Behaviour:
- clr asserted (asynchronous): state=IDLE; every output 0, including alu_sel; latched operands and counter cleared. Takes effect mid-sequence; no partial strobe persists past the clr edge.
- Outputs are a Moore decode of the registered state plus latched fields. Strobes not listed for a state are 0.
- IDLE: start=1 with ra, rb and rc all < NUM_REGS latches op/wide/ra/rb/rc -> T3. If any index >= NUM_REGS -> ERR. start=0 -> stay.
- ERR: err=1, busy=1 -> IDLE. Nothing is latched.
- T3: Rout[rb]=1, Yin=1 -> T4. The counter is loaded with (wide ? WIDE_LAT : ALU_LAT) - 1.
- T4: Rout[rc]=1, alu_sel=op, Zin=1.
  - Counter != 0: decrement and stay.
  - Counter = 0: -> T5.
  - Zin and alu_sel stay high for the full hold; Z captures on every edge.
- T5: ZLOout=1.
  - Narrow op: Rin[ra]=1 -> DONE.
  - Wide op: LOin=1 -> T6.
- T6 (wide only): ZHIout=1, HIin=1 -> DONE.
- DONE: done=1, busy=1 -> IDLE.
- start while busy: ignored and not queued. Operand inputs may change freely after the accepting edge; latched copies are used.
- ra=rb=rc is legal. For example, R3-R3->R3 strobes Rout[3] in T3 and T4 and Rin[3] in T5.
- Exactly one bus driver per state: Rout, ZLOout and ZHIout are never high in the same cycle. Rin, LOin and HIin are never high together.
- Latency from the accepting edge to done high:
  - Narrow op: 3 + ALU_LAT cycles.
  - Wide op: 4 + WIDE_LAT cycles.
- Next start is accepted on the edge after done, when state=IDLE.
- No datapath values pass through this block; widths of data are irrelevant.

Test Plan:
1. Narrow sub. Defaults; R4=10, R5=2 preloaded via MDR; start with op=5'b00010, rb=4, rc=5, ra=0.
   -> Cycle-exact strobes: T3 Rout[4]+Yin, T4 Rout[5]+Zin+alu_sel=00010, T5 ZLOout+Rin[0], then done.
   -> R0=8; done 4 cycles after the start edge.
2. Wide op. op=mul, wide=1, R4=0x10000, R5=0x10000, WIDE_LAT=4.
   -> T4 held 4 cycles; T5 ZLOout+LOin; T6 ZHIout+HIin.
   -> LO=0, HI=1; done 8 cycles after start; Rin stays 0 throughout.
3. Busy and back-to-back.
   -> A start pulse during T4 is ignored: no second sequence, operands unchanged.
   -> start held high through done launches the second op on the edge after done: busy low exactly 1 cycle (IDLE).
4. Reset mid-op. Assert clr during T4, asynchronously and away from a clk edge.
   -> All outputs 0 immediately; next start runs a full clean sequence.
5. Illegal index. NUM_REGS=12; start with rc=13.
   -> err pulses 1 cycle, busy high for that cycle, no strobes, back in IDLE.
   -> A following legal start with rb=11 succeeds.
6. Aliasing and latency bound. ra=rb=rc=3, ALU_LAT=1 vs ALU_LAT=3.
   -> Correct strobes; T4 lasts 1 vs 3 cycles; the one-hot and single-driver checks hold on every cycle.
